char_text_buffer: RTL and testbench
===================================

# char_text_buffer

Character text RAM feeding the character-overlay draw stage through the font ROM. It holds a 16x16 grid of 7-bit character codes. The draw stage addresses it with `{row, col}` and the current glyph line, and the block returns the registered font ROM address. Game logic writes it through a random-access port and a cursor-driven stream port, and a sweeping clear FSM fills the grid with a blank character.

## Interface
Parameters:
- CLEAR_CHAR, 7'h20: code written to every cell by a clear.
- AUTO_CLEAR, 1: when 1, the block runs a full clear after reset; when 0, it comes out of reset in IDLE.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- char_yx  in  8  read cell address `{row[3:0], col[3:0]}` from the draw stage.
- char_line  in  4  glyph line, 0..15, from the draw stage.
- font_addr  out  11  `{char_code[6:0], line[3:0]}` to the font ROM; registered.
- wr_valid  in  1  random-access write request.
- wr_ready  out  1  random-access write accepted when `wr_valid && wr_ready`.
- wr_yx  in  8  write cell address `{row, col}`.
- wr_char  in  7  code to write.
- put_valid  in  1  cursor-stream request.
- put_ready  out  1  cursor-stream accepted when `put_valid && put_ready`.
- put_char  in  7  code to write at the cursor; 7'h0A is newline.
- clr  in  1  single-cycle clear request.
- busy  out  1  high while a clear is running.
- cursor  out  8  current cursor `{row, col}`.

## Operation
- Storage: 256 x 7 synchronous RAM. Contents are not reset. Write and read ports are independent. A read and a write to the same cell in the same cycle return the old data (read-first).
- Read path: `char_yx` and `char_line` are sampled on the same clk edge. `font_addr` is the RAM data concatenated with the registered `char_line`. The read port is always active, including during a clear.
- FSM states:
  - IDLE: accepts writes. Goes to CLEAR on `clr`.
  - CLEAR: an 8-bit sweep counter writes CLEAR_CHAR to cells 0..255, one per cycle. Returns to IDLE after cell 255 is written.
- Ready outputs:
  - `busy` = (state == CLEAR).
  - `wr_ready` = IDLE && !clr.
  - `put_ready` = IDLE && !clr && !wr_valid.
  - Priority is: clr, then random-access write, then stream.
- Stream accept with `put_char` != 7'h0A: the block writes the cell at `cursor`, then increments `cursor` as an 8-bit value. Column 15 wraps to column 0 of the next row; cell 0xFF wraps to 0x00.
- Stream accept with `put_char` == 7'h0A: no RAM write. `cursor` becomes `{row+1, 4'h0}`; row 15 wraps to row 0.
- Random-access writes never move `cursor`.
- Clear: `cursor` is set to 0x00 on the first CLEAR cycle. A `clr` while already in CLEAR is ignored; the sweep does not restart.
- Reset:
  - State goes to CLEAR when AUTO_CLEAR=1, otherwise IDLE. Sweep counter = 0, `cursor` = 0x00, `font_addr` = 0.
  - Asserting `rst_n` mid-clear aborts the clear. After release, with AUTO_CLEAR=1, the sweep restarts from cell 0.

## Timing
- Read latency: 1 cycle. `char_yx`/`char_line` sampled at edge N produce `font_addr` valid after edge N. The two inputs stay aligned.
- Write commit: an accepted write at edge N updates the RAM at edge N. A read of that cell sampled at edge N+1 or later returns the new code.
- Clear timing:
  - `clr` sampled at edge N gives `busy`=1 from edge N to edge N+256, covering 256 write cycles.
  - `wr_ready`/`put_ready` are low over the same span and return high after edge N+256.
  - After reset with AUTO_CLEAR=1, `busy` is high for the first 256 cycles.
- Ready timing: `wr_ready` and `put_ready` are combinational from state, `clr` and `wr_valid`. No other path lets an input drive an output combinationally.

## Structure
- Shared package constants: GRID_COLS=16, GRID_ROWS=16, CHAR_W=7, LINE_W=4, NEWLINE=7'h0A, and the FSM state enum {IDLE, CLEAR}. The font-ROM address layout `{code, line}` also belongs there, so the font ROM and the draw stage share it.
- Sub-module `text_ram_256x7`: single-clock RAM with one write port and one registered read port, read-first, inferable as block RAM.
- The top level holds the FSM, cursor, arbitration and the `font_addr` register.

## Test plan
- Reset with AUTO_CLEAR=1, hold `char_yx`=8'h00 and `char_line`=3 -> `busy` high for 256 cycles; afterwards `font_addr`=11'h203 for every `char_yx`.
- Write `wr_yx`=8'h3A, `wr_char`=7'h41; next cycle read `char_yx`=8'h3A, `char_line`=5 -> `font_addr`=11'h415 one cycle later; `cursor` unchanged.
- Start with `cursor`=0xFE and stream 'A','B','C' -> cells 0xFE, 0xFF, 0x00 hold 0x41, 0x42, 0x43; `cursor`=0x01.
- Start with `cursor`=0x25 and stream 7'h0A -> `cursor`=0x30, no cell changes. From `cursor`=0xF7, 7'h0A -> `cursor`=0x00.
- Drive `wr_valid` and `put_valid` in the same cycle -> only the random-access write is taken, `put_ready`=0, and the stream char is accepted the next cycle.
- Pulse `clr` mid-stream, then assert `rst_n` low at sweep cell 100 -> outputs go to their reset values immediately. After release, `busy` lasts a full 256 cycles and every cell reads CLEAR_CHAR.

Source files
------------

// File: rtl/char_text_buffer_pkg.sv
// Shared constants and types for the character overlay: grid geometry, code
// widths, the clear FSM states and the font ROM address layout {code, line}.
package char_text_buffer_pkg;

  localparam int GRID_COLS   = 16;
  localparam int GRID_ROWS   = 16;
  localparam int CELLS       = GRID_COLS * GRID_ROWS;
  localparam int CHAR_W      = 7;
  localparam int LINE_W      = 4;
  localparam int FONT_ADDR_W = CHAR_W + LINE_W;

  localparam logic [CHAR_W-1:0] NEWLINE = 7'h0A;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // The font ROM and the draw stage both decode this layout.
  typedef struct packed {
    logic [CHAR_W-1:0] code;
    logic [LINE_W-1:0] line;
  } font_addr_t;

  function automatic logic [FONT_ADDR_W-1:0] font_addr_of(
    input logic [CHAR_W-1:0] code,
    input logic [LINE_W-1:0] line
  );
    font_addr_t f;
    f.code = code;
    f.line = line;
    return f;
  endfunction

endpackage

// File: rtl/char_text_buffer_ram.sv
// 256 x 7 character RAM: one write port, one registered read port, read-first.
// No reset so it maps onto block RAM.
module text_ram_256x7
  import char_text_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [7:0]        raddr,
  output logic [CHAR_W-1:0] rdata
);

  logic [CHAR_W-1:0] mem [CELLS];

  // Same-cell read and write in one cycle returns the old code.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/char_text_buffer.sv
// Character text buffer: clear FSM, cursor stream port, random-access write port
// and the registered font ROM address for the overlay draw stage.
module char_text_buffer
  import char_text_buffer_pkg::*;
#(
  parameter logic [6:0] CLEAR_CHAR = 7'h20,
  parameter bit         AUTO_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  char_yx,
  input  logic [3:0]  char_line,
  output logic [10:0] font_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_yx,
  input  logic [6:0]  wr_char,
  input  logic        put_valid,
  output logic        put_ready,
  input  logic [6:0]  put_char,
  input  logic        clr,
  output logic        busy,
  output logic [7:0]  cursor
);

  state_t            state_reg;
  logic [7:0]        sweep_reg;
  logic [7:0]        cursor_reg;
  logic [3:0]        line_reg;
  logic              rd_valid_reg;

  logic              idle;
  logic              wr_fire;
  logic              put_fire;
  logic              put_newline;
  logic              ram_we;
  logic [7:0]        ram_waddr;
  logic [CHAR_W-1:0] ram_wdata;
  logic [CHAR_W-1:0] ram_rdata;

  assign idle        = (state_reg == IDLE);
  assign busy        = (state_reg == CLEAR);
  assign wr_ready    = idle && !clr;
  assign put_ready   = idle && !clr && !wr_valid;
  assign wr_fire     = wr_valid && wr_ready;
  assign put_fire    = put_valid && put_ready;
  assign put_newline = (put_char == NEWLINE);
  assign cursor      = cursor_reg;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cursor_reg;
    ram_wdata = put_char;
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_reg;
      ram_wdata = CLEAR_CHAR;
    end else if (wr_fire) begin
      ram_we    = 1'b1;
      ram_waddr = wr_yx;
      ram_wdata = wr_char;
    end else if (put_fire && !put_newline) begin
      ram_we    = 1'b1;
    end
  end

  text_ram_256x7 u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (char_yx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= AUTO_CLEAR ? CLEAR : IDLE;
      sweep_reg    <= 8'h00;
      cursor_reg   <= 8'h00;
      line_reg     <= 4'h0;
      rd_valid_reg <= 1'b0;
    end else begin
      line_reg     <= char_line;
      rd_valid_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (clr) begin
            state_reg <= CLEAR;
            sweep_reg <= 8'h00;
          end else if (put_fire) begin
            cursor_reg <= put_newline ? {cursor_reg[7:4] + 4'd1, 4'h0}
                                      : cursor_reg + 8'd1;
          end
        end
        CLEAR: begin
          cursor_reg <= 8'h00;
          sweep_reg  <= sweep_reg + 8'd1;
          if (sweep_reg == 8'hFF) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // RAM output has no reset; hold the address at zero until the first read lands.
  assign font_addr = rd_valid_reg ? font_addr_of(ram_rdata, line_reg) : 11'h000;

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed bench for char_text_buffer: auto-clear, random writes, cursor stream,
// arbitration, clr and mid-clear reset.
module tb_char_text_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  char_yx;
  logic [3:0]  char_line;
  logic [10:0] font_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_yx;
  logic [6:0]  wr_char;
  logic        put_valid;
  logic        put_ready;
  logic [6:0]  put_char;
  logic        clr;
  logic        busy;
  logic [7:0]  cursor;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  char_text_buffer #(
    .CLEAR_CHAR (7'h20),
    .AUTO_CLEAR (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_yx   (char_yx),
    .char_line (char_line),
    .font_addr (font_addr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_yx     (wr_yx),
    .wr_char   (wr_char),
    .put_valid (put_valid),
    .put_ready (put_ready),
    .put_char  (put_char),
    .clr       (clr),
    .busy      (busy),
    .cursor    (cursor)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input logic [7:0] yx, input logic [3:0] ln, input logic [10:0] exp, input string tag);
    char_yx   = yx;
    char_line = ln;
    tick();
    check_vec(tag, font_addr, exp);
  endtask

  task automatic put(input logic [6:0] ch);
    put_valid = 1'b1;
    put_char  = ch;
    tick();
    put_valid = 1'b0;
    $display("put %02h -> cursor %02h", ch, cursor);
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check_vec(tag, n, 256);
  endtask

  initial begin
    rst_n = 1'b0; char_yx = 8'h00; char_line = 4'd3;
    wr_valid = 1'b0; wr_yx = 8'h00; wr_char = 7'h00;
    put_valid = 1'b0; put_char = 7'h00; clr = 1'b0;

    // Reset state and auto-clear
    #12;
    check_vec("rst_busy", busy, 1);
    check_vec("rst_font_addr", font_addr, 11'h000);
    check_vec("rst_cursor", cursor, 8'h00);
    check_vec("rst_wr_ready", wr_ready, 0);
    tick();
    rst_n = 1'b1;
    count_busy("auto_clear_len");
    check_vec("post_clear_wr_ready", wr_ready, 1);
    for (int i = 0; i < 256; i++) begin
      read_cell(i[7:0], 4'd3, 11'h203, "blank_cell");
    end

    // Random write with read-first collision, then readback
    wr_valid = 1'b1; wr_yx = 8'h3A; wr_char = 7'h41;
    char_yx = 8'h3A; char_line = 4'd5;
    tick();
    wr_valid = 1'b0;
    $display("write %02h <- %02h", 8'h3A, 7'h41);
    check_vec("read_first_old", font_addr, 11'h205);
    read_cell(8'h3A, 4'd5, 11'h415, "wr_readback");
    check_vec("wr_cursor_still", cursor, 8'h00);

    // Stream wrap across 0xFF
    for (int i = 0; i < 15; i++) put(7'h0A);
    check_vec("nl_to_f0", cursor, 8'hF0);
    for (int i = 0; i < 14; i++) put(7'h78);
    check_vec("cursor_fe", cursor, 8'hFE);
    put(7'h41); put(7'h42); put(7'h43);
    check_vec("cursor_wrap", cursor, 8'h01);
    read_cell(8'hFE, 4'd0, 11'h410, "cell_fe");
    read_cell(8'hFF, 4'd0, 11'h420, "cell_ff");
    read_cell(8'h00, 4'd0, 11'h430, "cell_00");

    // Newline handling
    put(7'h0A); put(7'h0A);
    for (int i = 0; i < 5; i++) put(7'h79);
    check_vec("cursor_25", cursor, 8'h25);
    put(7'h0A);
    check_vec("nl_cursor_30", cursor, 8'h30);
    read_cell(8'h25, 4'd0, 11'h200, "nl_no_write_25");
    read_cell(8'h30, 4'd0, 11'h200, "nl_no_write_30");
    for (int i = 0; i < 12; i++) put(7'h0A);
    for (int i = 0; i < 7; i++) put(7'h79);
    check_vec("cursor_f7", cursor, 8'hF7);
    put(7'h0A);
    check_vec("nl_row_wrap", cursor, 8'h00);
    read_cell(8'hF7, 4'd0, 11'h780, "nl_no_write_f7");

    // Random write beats stream in the same cycle
    wr_valid = 1'b1; wr_yx = 8'h80; wr_char = 7'h55;
    put_valid = 1'b1; put_char = 7'h66;
    #1;
    check_vec("both_wr_ready", wr_ready, 1);
    check_vec("both_put_ready", put_ready, 0);
    tick();
    wr_valid = 1'b0;
    #1;
    check_vec("put_ready_next", put_ready, 1);
    check_vec("cursor_held", cursor, 8'h00);
    tick();
    put_valid = 1'b0;
    check_vec("put_taken", cursor, 8'h01);
    read_cell(8'h80, 4'd2, 11'h552, "arb_wr_cell");
    read_cell(8'h00, 4'd2, 11'h662, "arb_put_cell");

    // Full clr with an ignored clr mid-sweep
    clr = 1'b1;
    #1;
    check_vec("clr_wr_ready", wr_ready, 0);
    tick();
    clr = 1'b0;
    begin
      int n = 0;
      while (busy && n < 1000) begin
        clr = (n == 10);
        tick();
        n++;
      end
      clr = 1'b0;
      check_vec("clr_len", n, 256);
    end
    check_vec("clr_cursor", cursor, 8'h00);
    read_cell(8'h80, 4'd1, 11'h201, "clr_cell_80");

    // clr mid-stream, then reset at sweep cell 100
    put(7'h4D); put(7'h4E);
    check_vec("pre_clr_cursor", cursor, 8'h02);
    put_valid = 1'b1; put_char = 7'h4F; clr = 1'b1;
    #1;
    check_vec("clr_put_ready", put_ready, 0);
    tick();
    clr = 1'b0; put_valid = 1'b0;
    check_vec("clr_busy", busy, 1);
    char_yx = 8'h80; char_line = 4'd7;
    for (int i = 0; i < 100; i++) tick();
    check_vec("pre_rst_font_addr", font_addr, 11'h207);
    rst_n = 1'b0;
    #1;
    check_vec("abort_font_addr", font_addr, 11'h000);
    check_vec("abort_cursor", cursor, 8'h00);
    check_vec("abort_busy", busy, 1);
    tick(); tick();
    rst_n = 1'b1;
    count_busy("restart_clear_len");
    for (int i = 0; i < 256; i++) begin
      read_cell(i[7:0], 4'd9, 11'h209, "final_blank");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
